// File: rtl/up_bus_combiner.sv
// Up-bus response combiner and status aggregator.
// Merges the write/read acks and read data of NUM_SLAVES register slaves into
// one registered response towards up_axi, tracks the outstanding transaction,
// synthesizes an ack when no slave answers within TIMEOUT_CYCLES, flags
// protocol errors, and ORs enabled per-channel status into core-level bits.
//
// Handshake: up_wreq/up_rreq are single-cycle request pulses; at most one
// transaction is outstanding. A slave answers with a single-cycle ack of the
// matching type (read data valid only while its rack is high). The combined
// ack/data appear on the outputs exactly one up_clk after the slave ack.
module up_bus_combiner #(
   parameter int          NUM_SLAVES     = 3,
   parameter int          NUM_CHANNELS   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 32,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD
) (
   input  logic                       up_clk,
   input  logic                       up_rstn,
   input  logic                       up_wreq,
   input  logic                       up_rreq,
   input  logic [NUM_SLAVES-1:0]      up_wack_in,
   input  logic [NUM_SLAVES-1:0]      up_rack_in,
   input  logic [32*NUM_SLAVES-1:0]   up_rdata_in,
   output logic                       up_wack,
   output logic                       up_rack,
   output logic [31:0]                up_rdata,
   input  logic [NUM_CHANNELS-1:0]    up_ch_pn_err,
   input  logic [NUM_CHANNELS-1:0]    up_ch_pn_oos,
   input  logic [NUM_CHANNELS-1:0]    up_ch_or,
   input  logic [NUM_CHANNELS-1:0]    up_ch_enable,
   output logic                       up_status_pn_err,
   output logic                       up_status_pn_oos,
   output logic                       up_status_or,
   output logic                       up_busy,
   output logic [15:0]                up_timeout_count,
   output logic                       up_proto_err,
   input  logic                       up_proto_err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_WAIT = 2'd1,
      ST_RD_WAIT = 2'd2
   } state_t;

   // Wait counter value on the last cycle a slave may still answer.
   localparam logic [31:0] LP_TO_LAST = TIMEOUT_CYCLES - 32'd1;
   localparam logic        LP_TO_EN   = (TIMEOUT_CYCLES != 0);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_wait_cnt;
   logic [31:0] w_wait_cnt_nxt;

   logic        r_wack;
   logic        r_rack;
   logic [31:0] r_rdata;
   logic [15:0] r_timeout_count;
   logic        r_proto_err;
   logic        r_status_pn_err;
   logic        r_status_pn_oos;
   logic        r_status_or;

   logic        w_any_wack;
   logic        w_any_rack;
   logic        w_multi_ack;
   logic [31:0] w_rdata_or;
   logic        w_wack_nxt;
   logic        w_rack_nxt;
   logic [31:0] w_rdata_nxt;
   logic        w_timeout;
   logic        w_drop_ack;
   logic        w_req_busy;
   logic        w_proto_set;

   assign w_any_wack  = |up_wack_in;
   assign w_any_rack  = |up_rack_in;
   assign w_multi_ack = !$onehot0(up_wack_in) || !$onehot0(up_rack_in);

   // OR of the read data of every slave currently asserting its rack.
   always_comb begin
      w_rdata_or = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (up_rack_in[i]) begin
            w_rdata_or = w_rdata_or | up_rdata_in[32*i +: 32];
         end
      end
   end

   // State register and wait counter.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Next state, response selection, timeout and ack-filtering decisions.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = '0;
      w_wack_nxt     = 1'b0;
      w_rack_nxt     = 1'b0;
      w_rdata_nxt    = '0;
      w_timeout      = 1'b0;
      w_drop_ack     = 1'b0;
      w_req_busy     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (up_rreq) begin
               // Read wins over a simultaneous write; any wack is unmatched.
               w_drop_ack = w_any_wack;
               if (w_any_rack) begin
                  w_rack_nxt  = 1'b1;
                  w_rdata_nxt = w_rdata_or;
               end else begin
                  w_state_nxt = ST_RD_WAIT;
               end
            end else if (up_wreq) begin
               w_drop_ack = w_any_rack;
               if (w_any_wack) begin
                  w_wack_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_WR_WAIT;
               end
            end else begin
               w_drop_ack = w_any_wack | w_any_rack;
            end
         end
         ST_WR_WAIT: begin
            w_req_busy = up_wreq | up_rreq;
            w_drop_ack = w_any_rack;
            if (w_any_wack) begin
               w_wack_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (LP_TO_EN && (r_wait_cnt == LP_TO_LAST)) begin
               w_wack_nxt  = 1'b1;
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 32'd1;
            end
         end
         ST_RD_WAIT: begin
            w_req_busy = up_wreq | up_rreq;
            w_drop_ack = w_any_wack;
            if (w_any_rack) begin
               w_rack_nxt  = 1'b1;
               w_rdata_nxt = w_rdata_or;
               w_state_nxt = ST_IDLE;
            end else if (LP_TO_EN && (r_wait_cnt == LP_TO_LAST)) begin
               w_rack_nxt  = 1'b1;
               w_rdata_nxt = TIMEOUT_RDATA;
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 32'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_proto_set = w_multi_ack | (up_wreq & up_rreq) | w_req_busy | w_drop_ack;

   // Registered response, saturating timeout count and sticky protocol error.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_wack          <= 1'b0;
         r_rack          <= 1'b0;
         r_rdata         <= '0;
         r_timeout_count <= '0;
         r_proto_err     <= 1'b0;
      end else begin
         r_wack  <= w_wack_nxt;
         r_rack  <= w_rack_nxt;
         r_rdata <= w_rdata_nxt;
         if (w_timeout && (r_timeout_count != 16'hFFFF)) begin
            r_timeout_count <= r_timeout_count + 16'd1;
         end
         if (w_proto_set) begin
            r_proto_err <= 1'b1;
         end else if (up_proto_err_clr) begin
            r_proto_err <= 1'b0;
         end
      end
   end

   // Enabled per-channel status ORed into core-level bits, not latched.
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_status_pn_err <= 1'b0;
         r_status_pn_oos <= 1'b0;
         r_status_or     <= 1'b0;
      end else begin
         r_status_pn_err <= |(up_ch_pn_err & up_ch_enable);
         r_status_pn_oos <= |(up_ch_pn_oos & up_ch_enable);
         r_status_or     <= |(up_ch_or & up_ch_enable);
      end
   end

   assign up_wack          = r_wack;
   assign up_rack          = r_rack;
   assign up_rdata         = r_rdata;
   assign up_timeout_count = r_timeout_count;
   assign up_proto_err     = r_proto_err;
   assign up_status_pn_err = r_status_pn_err;
   assign up_status_pn_oos = r_status_pn_oos;
   assign up_status_or     = r_status_or;
   assign up_busy          = (r_state != ST_IDLE);

endmodule
